// File: rtl/serial_slt_unit_if.sv
// Operand/result handshake bundle for the bit-serial add/sub/SLT engine.
// The issuer/consumer side uses master and the engine uses slave.
interface serial_slt_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carryout, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carryout, overflow
  );
endinterface

// File: rtl/serial_slt_unit.sv
// Bit-serial ADD/SUB/SLT engine: one sum bit per cycle, LSB first, with
// valid/ready handshakes on the operand and result sides.
module serial_slt_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_slt_unit_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SLT = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  op_t              op_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, ovf_q;

  logic in_ready_d, out_valid_d;
  logic accept, last_bit;
  logic sum_bit, cout_bit, ovf_bit;
  logic sub_like;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    last_bit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        last_bit = (cnt_q == LAST_BIT);
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = in_ready_d & bus.in_valid;
  assign sub_like = (op_t'(bus.op) == OP_SUB) || (op_t'(bus.op) == OP_SLT);

  // Full-adder slice on the current LSB; at the last bit c_q is the carry into the MSB.
  assign sum_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign cout_bit = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign ovf_bit  = c_q ^ cout_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      cnt_q  <= '0;
      c_q    <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.a;
        b_q   <= sub_like ? ~bus.b : bus.b;
        op_q  <= op_t'(bus.op);
        c_q   <= sub_like;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        a_q <= a_q >> 1;
        b_q <= b_q >> 1;
        c_q <= cout_bit;
        if (!last_bit) begin
          cnt_q <= cnt_q + 1'b1;
          res_q <= {sum_bit, res_q[WIDTH-1:1]};
        end else if (op_q == OP_SLT) begin
          // Signed less-than is the sign of A-B corrected by overflow.
          res_q  <= {{(WIDTH-1){1'b0}}, sum_bit ^ ovf_bit};
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else begin
          res_q  <= {sum_bit, res_q[WIDTH-1:1]};
          cout_q <= cout_bit;
          ovf_q  <= ovf_bit;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = out_valid_d;
  assign bus.result    = res_q;
  assign bus.carryout  = cout_q;
  assign bus.overflow  = ovf_q;

endmodule
